// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder fronting a word-addressed register array (Get/PutFull/PutPartial).
// Latency: D response is registered one cycle after A acceptance, sustaining one response per cycle.
// Backpressure: a_ready = ~d_valid | d_ready; a held D response stalls channel A until consumed.
module tl_ul_sram_responder #(
    parameter logic [30:0] BASE_ADDR = 31'h0800_0000,
    parameter int          DEPTH     = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [2:0]  a_size,
    input  logic [4:0]  a_source,
    input  logic [30:0] a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    input  logic        a_corrupt,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [2:0]  d_size,
    output logic [4:0]  d_source,
    output logic        d_sink,
    output logic        d_denied,
    output logic [31:0] d_data,
    output logic        d_corrupt,
    output logic [7:0]  denied_count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int WIN_W = IDX_W + 2;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGIC       = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_INTENT      = 3'd5;

    localparam logic [2:0] D_ACK      = 3'd0;
    localparam logic [2:0] D_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK = 3'd2;

    logic [31:0]      mem [DEPTH];
    logic             accept;
    logic             hit;
    logic             aligned;
    logic             isPut;
    logic             isGet;
    logic             legal;
    logic             doWrite;
    logic [IDX_W-1:0] wordIdx;
    logic [2:0]       respOpcode;
    logic [31:0]      respData;
    logic             respCorrupt;
    logic             unusedAParam;

    assign unusedAParam = ^a_param;

    assign a_ready = ~d_valid | d_ready;
    assign accept  = a_valid & a_ready;
    assign d_param = 2'd0;
    assign d_sink  = 1'b0;

    // The window is aligned to its own size, so a match on the upper bits is the range test.
    assign hit     = (a_address[30:WIN_W] == BASE_ADDR[30:WIN_W]);
    assign wordIdx = a_address[WIN_W-1:2];
    assign isPut   = (a_opcode == OP_PUT_FULL) | (a_opcode == OP_PUT_PARTIAL);
    assign isGet   = (a_opcode == OP_GET);

    always_comb begin
        aligned = 1'b0;
        case (a_size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~a_address[0];
            3'd2:    aligned = (a_address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign legal   = hit & aligned & (isGet | (isPut & ~a_corrupt));
    assign doWrite = accept & legal & isPut;

    always_comb begin
        respOpcode  = D_ACK;
        respData    = 32'd0;
        respCorrupt = 1'b0;
        if (legal) begin
            if (isGet) begin
                respOpcode = D_ACK_DATA;
                respData   = mem[wordIdx];
            end
        end else begin
            case (a_opcode)
                OP_GET, OP_ARITH, OP_LOGIC: begin
                    respOpcode  = D_ACK_DATA;
                    respCorrupt = 1'b1;
                end
                OP_INTENT: respOpcode = D_HINT_ACK;
                default:   respOpcode = D_ACK;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (a_mask[i]) mem[wordIdx][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_valid      <= 1'b0;
            d_opcode     <= 3'd0;
            d_size       <= 3'd0;
            d_source     <= 5'd0;
            d_denied     <= 1'b0;
            d_data       <= 32'd0;
            d_corrupt    <= 1'b0;
            denied_count <= 8'd0;
        end else if (accept) begin
            d_valid   <= 1'b1;
            d_opcode  <= respOpcode;
            d_size    <= a_size;
            d_source  <= a_source;
            d_denied  <= ~legal;
            d_data    <= respData;
            d_corrupt <= respCorrupt;
            if (~legal && denied_count != 8'hFF) denied_count <= denied_count + 8'd1;
        end else if (d_ready) begin
            d_valid <= 1'b0;
        end
    end
endmodule
